// File: rtl/quantizer.sv
// Quantizer: takes row-major DCT coefficients, looks up the per-index inverse-quantization
// byte from an external registered ROM, multiplies and rounds, and streams the result out.
module quantizer #(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic [COEF_W-1:0] in_coef,
  output logic [5:0]        romq_a,
  input  logic [7:0]        romq_d,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [COEF_W-1:0] o_data,
  output logic [5:0]        o_idx,
  output logic              o_last
);

  localparam int ProdW = COEF_W + 9;
  localparam logic signed [ProdW-1:0] RoundBias = ProdW'(128);

  logic                     en;
  logic [5:0]               idx_cnt;
  logic [5:0]               acc_idx;
  logic                     s1_valid;
  logic [5:0]               s1_idx;
  logic [COEF_W-1:0]        s1_coef;
  logic signed [ProdW-1:0]  prod;
  logic signed [ProdW-1:0]  prod_rnd;

  assign en       = !o_valid || o_ready;
  assign in_ready = en;
  assign acc_idx  = in_sop ? 6'd0 : idx_cnt;

  // While stalled, keep addressing the held entry so romq_d stays aligned with stage 1.
  assign romq_a = en ? acc_idx : s1_idx;

  // ROM byte is unsigned: widen with a zero MSB before the signed multiply.
  assign prod     = ProdW'($signed(s1_coef)) * ProdW'($signed({1'b0, romq_d}));
  assign prod_rnd = prod + RoundBias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_coef  <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_idx    <= '0;
      o_last   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_coef <= in_coef;
        s1_idx  <= acc_idx;
        idx_cnt <= acc_idx + 6'd1;
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        // |result| <= |coef|, so dropping the upper bits never loses information.
        o_data <= COEF_W'(prod_rnd >>> 8);
        o_idx  <= s1_idx;
        o_last <= (s1_idx == 6'd63);
      end
    end
  end

endmodule

// File: tb/tb_quantizer.sv
// Directed bench for quantizer: registered ROM model, expected-output queue, literal spot checks.
module tb_quantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sop;
  logic [11:0] in_coef;
  logic [5:0]  romq_a;
  logic [7:0]  romq_d;
  logic        o_valid, o_ready, o_last;
  logic [11:0] o_data;
  logic [5:0]  o_idx;

  quantizer #(.COEF_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_coef(in_coef), .romq_a(romq_a), .romq_d(romq_d), .o_valid(o_valid),
    .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx), .o_last(o_last)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [64];
  always_ff @(posedge clk) romq_d <= rom[romq_a];

  typedef struct packed {
    logic signed [11:0] d;
    logic [5:0]         i;
    logic               l;
  } exp_t;

  exp_t               sb[$];
  logic [5:0]         m_cnt;
  logic signed [11:0] last_d;
  logic [5:0]         last_i;
  logic               last_l;
  int                 total = 0;
  int                 bad = 0;
  int                 popped = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [11:0] qref(input logic signed [11:0] c, input logic [5:0] i);
    int p;
    p = int'(c) * int'(rom[i]);
    return 12'((p + 128) >>> 8);
  endfunction

  // Inputs change at edge+1, handshakes are judged at edge+2, returns at next edge+1.
  task automatic step(input logic v, input logic sop, input logic [11:0] c, input logic rdy,
                      output logic took);
    exp_t e;
    logic [5:0] ix;
    in_valid = v; in_sop = sop; in_coef = c; o_ready = rdy;
    #1;
    took = in_valid && in_ready;
    if (o_valid && o_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("o_data", $signed(o_data), e.d);
        chk("o_idx", o_idx, e.i);
        chk("o_last", o_last, e.l);
        last_d = $signed(o_data); last_i = o_idx; last_l = o_last;
        popped++;
      end
    end
    if (took) begin
      ix = sop ? 6'd0 : m_cnt;
      m_cnt = ix + 6'd1;
      e.d = qref(c, ix); e.i = ix; e.l = (ix == 6'd63);
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic t;
    for (int n = 0; n < 100 && sb.size() > 0; n++) step(1'b0, 1'b0, 12'd0, 1'b1, t);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic t;
    logic held;
    int   acc;
    int   cyc;
    logic signed [11:0] c;

    for (int i = 0; i < 64; i++) rom[i] = 8'(255 - 3 * i);
    rom[10] = 8'h5D; rom[11] = 8'h4C; rom[63] = 8'h19;
    in_valid = 0; in_sop = 0; in_coef = 0; o_ready = 1; m_cnt = 0;
    last_d = 0; last_i = 0; last_l = 0;
    rst_n = 0;
    #23;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_idx", o_idx, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_romq_a", romq_a, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;

    // Block of +100, with 2-cycle latency check on the first coefficient.
    step(1'b1, 1'b1, 12'd100, 1'b1, t);
    chk("lat_not_yet", o_valid, 0);
    step(1'b1, 1'b0, 12'd100, 1'b1, t);
    chk("lat_valid", o_valid, 1);
    chk("lat_idx0", o_idx, 0);
    chk("lat_data100", $signed(o_data), 100);
    for (int k = 2; k < 64; k++) step(1'b1, 1'b0, 12'd100, 1'b1, t);
    drain();
    chk("blk1_last_idx", last_i, 63);
    chk("blk1_last_data", last_d, 10);
    chk("blk1_last_flag", last_l, 1);

    // Extremes at index 0.
    step(1'b1, 1'b1, 12'h800, 1'b1, t);
    drain();
    chk("neg_max", last_d, -2040);
    step(1'b1, 1'b1, 12'h7FF, 1'b1, t);
    drain();
    chk("pos_max", last_d, 2039);

    // Zero at idx 0 and -1 at idx 63.
    step(1'b1, 1'b1, 12'd0, 1'b1, t);
    drain();
    chk("zero", last_d, 0);
    for (int k = 1; k < 63; k++) step(1'b1, 1'b0, 12'(k * 5 - 150), 1'b1, t);
    step(1'b1, 1'b0, 12'hFFF, 1'b1, t);
    drain();
    chk("m1_idx63", last_i, 63);
    chk("m1_data", last_d, 0);
    chk("m1_last", last_l, 1);

    // Backpressure while idx 10 sits on the output.
    held = 0;
    for (int k = 0; k < 64; k++) begin
      c = (k == 10) ? 12'sd300 : (k == 11) ? -12'sd300 : 12'(k * 7 - 200);
      if (!held && o_valid && o_idx == 6'd10) begin
        held = 1;
        for (int s = 0; s < 5; s++) begin
          step(1'b1, 1'b0, c, 1'b0, t);
          chk("bp_no_accept", t, 0);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_idx_hold", o_idx, 10);
          chk("bp_data_hold", $signed(o_data), 109);
        end
        step(1'b1, 1'b0, c, 1'b1, t);
        chk("bp_idx11", o_idx, 11);
        chk("bp_data11", $signed(o_data), -89);
      end else begin
        step(1'b1, k == 0, c, 1'b1, t);
      end
    end
    chk("bp_stalled", held, 1);
    drain();

    // Random bubbles and backpressure over three blocks.
    popped = 0;
    acc = 0;
    cyc = 0;
    while (acc < 192 && cyc < 3000) begin
      step(1'($urandom_range(0, 3) != 0), (acc % 64) == 0, 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 2) != 0), t);
      if (t) acc++;
      cyc++;
    end
    chk("rand_accepted", acc, 192);
    drain();
    chk("rand_count", popped, 192);

    // Mid-block in_sop on the 20th coefficient.
    for (int k = 0; k < 20; k++)
      step(1'b1, k == 0 || k == 19, (k == 19) ? 12'd50 : 12'(k * 3), 1'b1, t);
    drain();
    chk("sop_mid_idx", last_i, 0);
    chk("sop_mid_data", last_d, 50);
    chk("sop_mid_last", last_l, 0);

    // Asynchronous reset mid-block with o_valid high.
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 12'd40, 1'b1, t);
    chk("pre_rst_valid", o_valid, 1);
    #2;
    rst_n = 0;
    in_valid = 0;
    #1;
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_idx", o_idx, 0);
    sb.delete();
    m_cnt = 0;
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 12'd77, 1'b1, t);
    drain();
    chk("post_rst_idx", last_i, 0);
    chk("post_rst_data", last_d, 77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quantizer.md
Name: quantizer

Overview:
- Quantization stage directly downstream of the DCT and of the inverse-quantization ROM (64 × 8-bit, byte-addressed, 1-cycle registered read).
- Accepts a stream of DCT coefficients in row-major order, 64 per 8×8 block.
- For each coefficient, drives the ROM address with the coefficient index, multiplies the coefficient by the returned unsigned inverse-quantization byte, rounds, and emits the quantized value on a valid/ready stream toward the entropy coder.

Parameters:
- COEF_W, 12, signed coefficient width on input and output.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  stage can accept the input this cycle.
- in_sop  in  1  marks the first coefficient (index 0) of a block; sampled only on a handshake.
- in_coef  in  COEF_W  signed DCT coefficient.
- romq_a  out  6  ROM byte address (row = a[5:3], column = a[2:0]).
- romq_d  in  8  ROM data, registered in ROM, valid one cycle after romq_a.
- o_valid  out  1  quantized output valid.
- o_ready  in  1  downstream accepts the output.
- o_data  out  COEF_W  signed quantized coefficient.
- o_idx  out  6  index 0..63 of o_data within its block.
- o_last  out  1  high with o_valid when o_idx == 63.

Behaviour:
- Reset (async assert, sync-safe release): o_valid = 0, o_data = 0, o_idx = 0, o_last = 0, idx_cnt = 0, s1_valid = 0. romq_a therefore resets to 0.
- Pipeline enable: en = !o_valid | o_ready. in_ready = en (combinational from o_valid and o_ready).
- Stage 0 (accept), on in_valid & en:
  - Capture s1_coef = in_coef and s1_idx = (in_sop ? 0 : idx_cnt); set s1_valid = 1.
  - idx_cnt becomes s1_idx + 1, modulo 64; it wraps 63 → 0.
  - If en is high and in_valid is low, s1_valid is cleared.
- ROM address: romq_a = en ? (in_sop ? 0 : idx_cnt) : s1_idx.
  - While stalled, the ROM re-reads the held entry, so romq_d stays aligned with s1.
- Stage 1 (multiply/round), on en & s1_valid:
  - prod = s1_coef (signed) × {1'b0, romq_d} (positive); width COEF_W + 9.
  - o_data = (prod + 128) >>> 8 (arithmetic shift), truncated to COEF_W. The result never overflows: |result| ≤ |coef|.
  - o_idx = s1_idx; o_last = (s1_idx == 63); o_valid = 1.
  - If en is high and s1_valid is low, o_valid is cleared.
- Stall: while o_valid & !o_ready, o_data, o_idx, o_last, s1_* and idx_cnt all hold, and no input is accepted.
- Latency: 2 cycles from input handshake to o_valid with no stall. Throughput is 1 coefficient/cycle.
- in_sop mid-block: forces index 0 and restarts the block. The previous partial block is emitted as-is, without o_last. No error flag.
- Missing in_sop: after index 63 the counter wraps, and the next coefficient is treated as index 0.
- Reset mid-block: in-flight data is discarded, and the next accepted coefficient is index 0.
- Bubbles (in_valid low) do not advance idx_cnt.

Test Plan:
- Reset then stream 64 coefficients of +100 with in_sop on the first, o_ready = 1 -> o_idx 0..63 in order, o_last only at 63. Idx 0 (romq byte 0xFF) gives (25500 + 128) >>> 8 = 100. Idx 63 (0x19) gives (2500 + 128) >>> 8 = 10. First o_valid 2 cycles after the first handshake.
- Extremes: coef = -2048 at idx 0 -> -2040. Coef = +2047 at idx 0 -> 2039. Coef = -1 at idx 63 -> 0. Coef = 0 -> 0.
- Backpressure: o_ready low for 5 cycles at idx 10 -> in_ready low, and o_data/o_idx held. On release, idx 10 and 11 emerge with the correct products (ROM entries 0x5D for idx 10, 0x4C for idx 11). No duplicates or losses.
- Random bubbles on in_valid plus random o_ready across 3 blocks -> output matches the reference model coefficient-for-coefficient, with indices contiguous per block.
- in_sop asserted at the 20th coefficient -> that coefficient is emitted with o_idx = 0 and uses ROM entry 0 (0xFF). No o_last for the aborted block.
- rst_n pulsed low asynchronously mid-block with o_valid high -> o_valid drops immediately. The next accepted coefficient gets o_idx = 0.
